// File: rtl/conv2d_window_scheduler_if.sv
// rtl/conv2d_window_scheduler_if.sv - control, memory and core bus of the 3x3 window scheduler
// master: the scheduler; slave: host, BRAMs and convolution core.
interface conv2d_window_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              wgt_rd_en;
  logic [3:0]        wgt_addr;
  logic [7:0]        wgt_data;
  logic              pix_rd_en;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_data;
  logic              conv_valid_in;
  logic [71:0]       conv_win;
  logic [71:0]       conv_wgt;
  logic [15:0]       conv_result;
  logic              conv_valid_out;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       out_data;

  modport master (
    input  start, wgt_data, pix_data, conv_result, conv_valid_out,
    output busy, done, err, wgt_rd_en, wgt_addr, pix_rd_en, pix_addr,
           conv_valid_in, conv_win, conv_wgt, out_we, out_addr, out_data
  );

  modport slave (
    output start, wgt_data, pix_data, conv_result, conv_valid_out,
    input  busy, done, err, wgt_rd_en, wgt_addr, pix_rd_en, pix_addr,
           conv_valid_in, conv_win, conv_wgt, out_we, out_addr, out_data
  );
endinterface

// File: rtl/conv2d_window_scheduler.sv
// rtl/conv2d_window_scheduler.sv - sequences 3x3 windows of a feature map through a 9-MAC core
// Loads weights once, then fetch/issue/wait/write per valid output position (stride 1, no padding).
module conv2d_window_scheduler #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  conv2d_window_scheduler_if.master bus
);

  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = $clog2(IMG_H);
  localparam int CNT_MAX = (TIMEOUT > 10) ? TIMEOUT : 10;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [XW-1:0] OX_LAST  = XW'(IMG_W - 3);
  localparam logic [YW-1:0] OY_LAST  = YW'(IMG_H - 3);
  localparam logic [CW-1:0] CNT_RD   = CW'(8);
  localparam logic [CW-1:0] CNT_FILL = CW'(9);
  localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [71:0]   win_q, win_d;
  logic [71:0]   wgt_q, wgt_d;
  logic [15:0]   res_q, res_d;
  logic          err_q, err_d;

  logic              rd_phase;
  logic              cap_phase;
  logic [3:0]        k_rd;
  logic [3:0]        k_cap;
  logic [1:0]        k_row;
  logic [1:0]        k_col;
  logic              last_pos;
  logic              wait_tmo;
  logic              wgt_rd;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr_c;
  logic [ADDR_W-1:0] out_addr_c;

  // The same counter indexes read issue (k) and, one cycle later, capture (k-1).
  assign rd_phase  = (cnt_q <= CNT_RD);
  assign cap_phase = (cnt_q != '0);
  assign k_rd      = cnt_q[3:0];
  assign k_cap     = cnt_q[3:0] - 4'd1;
  assign last_pos  = (ox_q == OX_LAST) && (oy_q == OY_LAST);
  assign wait_tmo  = (cnt_q == CNT_TMO) && !bus.conv_valid_out;

  always_comb begin
    k_row = 2'd0;
    k_col = 2'd0;
    if (k_rd >= 4'd6) begin
      k_row = 2'd2;
      k_col = 2'(k_rd - 4'd6);
    end else if (k_rd >= 4'd3) begin
      k_row = 2'd1;
      k_col = 2'(k_rd - 4'd3);
    end else begin
      k_col = k_rd[1:0];
    end
  end

  assign pix_addr_c = ADDR_W'((32'(oy_q) + 32'(k_row)) * 32'(IMG_W) + 32'(ox_q) + 32'(k_col));
  assign out_addr_c = ADDR_W'(32'(oy_q) * 32'(IMG_W - 2) + 32'(ox_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_LOAD_W;
      S_LOAD_W: if (cnt_q == CNT_FILL) state_d = S_FETCH;
      S_FETCH:  if (cnt_q == CNT_FILL) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (bus.conv_valid_out) state_d = S_WRITE;
        else if (wait_tmo)      state_d = S_DONE;
      end
      S_WRITE:  state_d = last_pos ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    ox_d  = ox_q;
    oy_d  = oy_q;
    win_d = win_q;
    wgt_d = wgt_q;
    res_d = res_q;
    err_d = err_q;
    // Counter restarts on every state change; it measures time spent in the current state.
    if ((state_d == state_q) &&
        (state_q == S_LOAD_W || state_q == S_FETCH || state_q == S_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ox_d  = '0;
          oy_d  = '0;
          err_d = 1'b0;
        end
      end
      S_LOAD_W: if (cap_phase) wgt_d[int'(k_cap)*8 +: 8] = bus.wgt_data;
      S_FETCH:  if (cap_phase) win_d[int'(k_cap)*8 +: 8] = bus.pix_data;
      S_WAIT: begin
        if (bus.conv_valid_out) res_d = bus.conv_result;
        else if (wait_tmo)      err_d = 1'b1;
      end
      S_WRITE: begin
        if (ox_q == OX_LAST) begin
          ox_d = '0;
          oy_d = last_pos ? '0 : oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
      win_q <= '0;
      wgt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      win_q <= win_d;
      wgt_q <= wgt_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  assign wgt_rd = (state_q == S_LOAD_W) && rd_phase;
  assign pix_rd = (state_q == S_FETCH) && rd_phase;

  always_comb begin
    bus.busy          = (state_q != S_IDLE);
    bus.done          = (state_q == S_DONE);
    bus.err           = err_q;
    bus.wgt_rd_en     = wgt_rd;
    bus.wgt_addr      = wgt_rd ? k_rd : 4'd0;
    bus.pix_rd_en     = pix_rd;
    bus.pix_addr      = pix_rd ? pix_addr_c : '0;
    bus.conv_valid_in = (state_q == S_ISSUE);
    bus.conv_win      = win_q;
    bus.conv_wgt      = wgt_q;
    bus.out_we        = (state_q == S_WRITE);
    bus.out_addr      = (state_q == S_WRITE) ? out_addr_c : '0;
    bus.out_data      = res_q;
  end

endmodule
